// File: rtl/ftc_pkg.sv
// rtl/ftc_pkg.sv - shared widths, token layout and mem_wen bit indices for the fetch pipe
package ftc_pkg;

    localparam int FTC_NODE_W    = 16;
    localparam int FTC_GEN_W     = 12;
    localparam int FTC_OPR_W     = 32;
    localparam int FTC_ADDR_W    = 14;
    localparam int FTC_BUF_DEPTH = 2;

    // An instruction is the operand word plus the 2-bit unary-op tag from gen[1:0]
    function automatic int ftc_ins_w(input int opr_w);
        return opr_w + 2;
    endfunction

    localparam int FTC_INS_W = ftc_ins_w(FTC_OPR_W);

    // mem_wen_i bit positions
    localparam int FTC_MW_IM = 1;
    localparam int FTC_MW_DM = 0;

    // Token layout at default widths; the pipe declares the same layout at its own widths
    typedef struct packed {
        logic [FTC_NODE_W-1:0] node;
        logic [FTC_GEN_W-1:0]  gen;
        logic [FTC_OPR_W-1:0]  opr0;
        logic [FTC_OPR_W-1:0]  opr1;
        logic                  mem_wen;
        logic [FTC_INS_W-1:0]  ins;
        logic                  perr;
    } ftc_token_t;

endpackage

// File: rtl/ftc_skid_fifo.sv
// rtl/ftc_skid_fifo.sv - DEPTH x W skid FIFO with push/pop/count, head shown combinationally
module ftc_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [W-1:0]     wdata_i,
    input  logic             pop_i,
    output logic [W-1:0]     rdata_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next pointers and occupancy; simultaneous push and pop keep the count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push_i && pop_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Entry storage, not reset: only slots below the count are ever shown
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/ftc_fetch_pipe.sv
// rtl/ftc_fetch_pipe.sv - fetch stage with IM read/write, S1 register and skid FIFO; FTC_PARITY_EN adds IM parity
module ftc_fetch_pipe
    import ftc_pkg::*;
#(
    parameter int NODE_W    = FTC_NODE_W,
    parameter int GEN_W     = FTC_GEN_W,
    parameter int OPR_W     = FTC_OPR_W,
    parameter int ADDR_W    = FTC_ADDR_W,
    parameter int BUF_DEPTH = FTC_BUF_DEPTH,
    parameter int INS_W     = ftc_ins_w(OPR_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [NODE_W-1:0] node_i,
    input  logic [GEN_W-1:0]  gen_i,
    input  logic [OPR_W-1:0]  opr0_i,
    input  logic [OPR_W-1:0]  opr1_i,
    input  logic [1:0]        mem_wen_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [NODE_W-1:0] node_o,
    output logic [GEN_W-1:0]  gen_o,
    output logic [OPR_W-1:0]  opr0_o,
    output logic [OPR_W-1:0]  opr1_o,
    output logic              mem_wen_o,
    output logic [INS_W-1:0]  ins_o,
    output logic              par_err_o
);

`ifdef FTC_PARITY_EN
    localparam int IM_W = INS_W + 1;
`else
    localparam int IM_W = INS_W;
`endif
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [NODE_W-1:0] node;
        logic [GEN_W-1:0]  gen;
        logic [OPR_W-1:0]  opr0;
        logic [OPR_W-1:0]  opr1;
        logic              mem_wen;
        logic [INS_W-1:0]  ins;
        logic              perr;
    } tok_t;

    localparam int TOK_W = $bits(tok_t);

    logic [IM_W-1:0]   im_q [2**ADDR_W];
    logic [IM_W-1:0]   wword;
    logic [IM_W-1:0]   rword;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              accept;
    logic              s1_valid_q;
    tok_t              s1_tok_q, s1_tok_d;
    tok_t              fifo_head;
    tok_t              out_tok;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [OCC_W-1:0]  occ;
    logic              push;
    logic              pop;

    // Tokens held by the stage: FIFO entries plus the one in S1
    assign occ        = {1'b0, fifo_cnt} + OCC_W'(s1_valid_q);
    assign in_ready_o = occ < OCC_W'(BUF_DEPTH);
    assign accept     = in_valid_i && in_ready_o && !rst;
    assign wr         = mem_wen_i[FTC_MW_IM];
    assign addr       = node_i[ADDR_W-1:0];
    assign rword      = im_q[addr];

`ifdef FTC_PARITY_EN
    assign wword = {^{gen_i[1:0], opr0_i}, gen_i[1:0], opr0_i};
`else
    assign wword = {gen_i[1:0], opr0_i};
`endif

    // Token captured into S1: writes forward the new word, reads take the stored one
    always_comb begin
        s1_tok_d         = '0;
        s1_tok_d.node    = node_i;
        s1_tok_d.gen     = gen_i;
        s1_tok_d.opr0    = opr0_i;
        s1_tok_d.opr1    = opr1_i;
        s1_tok_d.mem_wen = mem_wen_i[FTC_MW_DM];
        s1_tok_d.ins     = wr ? wword[INS_W-1:0] : rword[INS_W-1:0];
`ifdef FTC_PARITY_EN
        s1_tok_d.perr    = !wr && (^rword);
`else
        s1_tok_d.perr    = 1'b0;
`endif
    end

    // Instruction memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            im_q[addr] <= wword;
        end
    end

    // S1 stage register: valid for exactly one cycle after acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_tok_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_tok_q <= s1_tok_d;
            end
        end
    end

    // S1 skips the FIFO only when nothing is queued ahead of it and Dec0 takes it now
    assign push = s1_valid_q && ((fifo_cnt != '0) || !out_ready_i);
    assign pop  = (fifo_cnt != '0) && out_ready_i;

    ftc_skid_fifo #(
        .DEPTH (BUF_DEPTH),
        .W     (TOK_W),
        .CNT_W (CNT_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (s1_tok_q),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .count_o (fifo_cnt)
    );

    // Output mux: oldest token first, FIFO head before S1
    always_comb begin
        out_tok = (fifo_cnt != '0) ? fifo_head : s1_tok_q;
    end

    assign out_valid_o = (fifo_cnt != '0) || s1_valid_q;
    assign node_o      = out_tok.node;
    assign gen_o       = out_tok.gen;
    assign opr0_o      = out_tok.opr0;
    assign opr1_o      = out_tok.opr1;
    assign mem_wen_o   = out_tok.mem_wen;
    assign ins_o       = out_tok.ins;
    assign par_err_o   = out_tok.perr;

endmodule
